// File: rtl/completion_monitor.sv
// Arms on start, watches per-channel power-off levels, captures and checks each
// channel's signature once per run, and reports pass / mismatch / timeout status.
module completion_monitor #(
    parameter int NCH   = 2,
    parameter int SIG_W = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NCH-1:0]       ch_enable,
    input  logic [CNT_W-1:0]     timeout_limit,
    input  logic [NCH*SIG_W-1:0] exp_sig,
    input  logic [NCH-1:0]       ch_poweroff,
    input  logic [NCH*SIG_W-1:0] ch_signature,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail_timeout,
    output logic [NCH-1:0]       fail_mask,
    output logic [NCH-1:0]       captured,
    output logic [CNT_W-1:0]     cycles
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [NCH-1:0]       en_q;
    logic [CNT_W-1:0]     limit_q;
    logic [NCH*SIG_W-1:0] exp_q;
    logic [NCH-1:0]       captured_q, captured_d;
    logic [NCH-1:0]       fail_mask_q, fail_mask_d;
    logic [CNT_W-1:0]     cycles_q, cycles_d;
    logic                 fail_to_q, busy_q, done_q, pass_q;

    logic [NCH-1:0]       mism, cap_now;
    logic [CNT_W:0]       cyc_inc;
    logic                 complete, timeout_hit;

    always_comb begin
        mism = '0;
        for (int i = 0; i < NCH; i++)
            mism[i] = (ch_signature[i*SIG_W +: SIG_W] != exp_q[i*SIG_W +: SIG_W]);
        cap_now     = en_q & ~captured_q & ch_poweroff;
        captured_d  = captured_q | cap_now;
        // Completion counts captures landing this cycle, so it beats a same-cycle timeout.
        complete    = ((captured_d & en_q) == en_q);
        cyc_inc     = {1'b0, cycles_q} + {{CNT_W{1'b0}}, 1'b1};
        timeout_hit = (limit_q != '0) && (cyc_inc == {1'b0, limit_q}) && !complete;
        cycles_d    = (&cycles_q) ? cycles_q : cyc_inc[CNT_W-1:0];
        fail_mask_d = fail_mask_q | (cap_now & mism)
                    | ({NCH{timeout_hit}} & en_q & ~captured_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= '0;
            limit_q     <= '0;
            exp_q       <= '0;
            captured_q  <= '0;
            fail_mask_q <= '0;
            cycles_q    <= '0;
            fail_to_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        en_q        <= ch_enable;
                        limit_q     <= timeout_limit;
                        exp_q       <= exp_sig;
                        captured_q  <= '0;
                        fail_mask_q <= '0;
                        cycles_q    <= '0;
                        fail_to_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    captured_q  <= captured_d;
                    fail_mask_q <= fail_mask_d;
                    cycles_q    <= cycles_d;
                    if (complete || timeout_hit) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        fail_to_q <= timeout_hit;
                        pass_q    <= complete && (fail_mask_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_timeout = fail_to_q;
    assign fail_mask    = fail_mask_q;
    assign captured     = captured_q;
    assign cycles       = cycles_q;

endmodule

// File: tb/tb_completion_monitor.sv
// Directed bench for completion_monitor: expected run results are queued when a
// run is armed and checked when done rises.
module tb_completion_monitor;

    localparam int NCH = 2, SIG_W = 32, CNT_W = 32;
    localparam logic [31:0] GOOD = 32'h3038345A;
    localparam logic [31:0] BAD  = 32'h3038345B;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic [NCH-1:0]       ch_enable, ch_poweroff;
    logic [CNT_W-1:0]     timeout_limit;
    logic [NCH*SIG_W-1:0] exp_sig, ch_signature;
    logic                 busy, done, pass, fail_timeout;
    logic [NCH-1:0]       fail_mask, captured;
    logic [CNT_W-1:0]     cycles;

    typedef struct {
        logic        pass;
        logic        to;
        logic [1:0]  mask;
        logic [1:0]  cap;
        logic [31:0] cyc;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    completion_monitor #(.NCH(NCH), .SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_enable(ch_enable),
        .timeout_limit(timeout_limit), .exp_sig(exp_sig), .ch_poweroff(ch_poweroff),
        .ch_signature(ch_signature), .busy(busy), .done(done), .pass(pass),
        .fail_timeout(fail_timeout), .fail_mask(fail_mask), .captured(captured),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic to, input logic [1:0] mask,
                        input logic [1:0] cap, input logic [31:0] cyc, input int len);
        exp_t e;
        e.pass = p; e.to = to; e.mask = mask; e.cap = cap; e.cyc = cyc; e.len = len;
        sb.push_back(e);
    endtask

    task automatic drive(input int k, input int pc0, input int pc1,
                         input logic [31:0] s0, input int chg0);
        ch_poweroff[0] = (pc0 >= 0) && (k >= pc0);
        ch_poweroff[1] = (pc1 >= 0) && (k >= pc1);
        ch_signature[31:0] = (chg0 > 0 && k >= chg0) ? ~s0 : s0;
    endtask

    // pcN: RUN cycle on which channel N's poweroff goes high (0 = already high, <0 = never).
    task automatic run(input string tag, input logic [1:0] en, input logic [31:0] lim,
                       input logic [31:0] s0, input logic [31:0] s1,
                       input int pc0, input int pc1, input int chg0, input int startk);
        int   k;
        exp_t e;
        ch_enable     = en;
        timeout_limit = lim;
        exp_sig       = {GOOD, GOOD};
        ch_signature  = {s1, s0};
        drive(0, pc0, pc1, s0, chg0);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        while (busy && k <= 200) begin
            drive(k, pc0, pc1, s0, chg0);
            start = (k == startk);
            tick();
            k++;
        end
        start = 1'b0;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy"}, busy, 0);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pass"}, pass, e.pass);
            chk({tag, ".fail_timeout"}, fail_timeout, e.to);
            chk({tag, ".fail_mask"}, fail_mask, e.mask);
            chk({tag, ".captured"}, captured, e.cap);
            chk({tag, ".cycles"}, cycles, e.cyc);
            chk({tag, ".run_len"}, k - 1, e.len);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".fail_timeout"}, fail_timeout, 0);
        chk({tag, ".fail_mask"}, fail_mask, 0);
        chk({tag, ".captured"}, captured, 0);
        chk({tag, ".cycles"}, cycles, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ch_enable = '0; ch_poweroff = '0;
        timeout_limit = '0; exp_sig = '0; ch_signature = '0;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("idle");

        // Nominal: ch0 on cycle 10, ch1 on cycle 20.
        push(1, 0, 2'b00, 2'b11, 20, 20);
        run("nominal", 2'b11, 1000, GOOD, GOOD, 10, 20, 0, 0);

        // DONE holds status while inputs wiggle.
        ch_poweroff = 2'b00; ch_signature = '0;
        tick(); tick(); tick();
        chk("hold.done", done, 1);
        chk("hold.pass", pass, 1);
        chk("hold.cycles", cycles, 20);
        chk("hold.captured", captured, 2'b11);

        push(0, 0, 2'b10, 2'b11, 20, 20);
        run("mismatch", 2'b11, 1000, GOOD, BAD, 10, 20, 0, 0);

        push(0, 1, 2'b10, 2'b01, 50, 50);
        run("timeout50", 2'b11, 50, GOOD, GOOD, 10, -1, 0, 0);

        push(0, 1, 2'b11, 2'b00, 3, 3);
        run("timeout_none", 2'b11, 3, GOOD, GOOD, -1, -1, 0, 0);

        push(1, 0, 2'b00, 2'b11, 5, 5);
        run("complete_wins", 2'b11, 5, GOOD, GOOD, 2, 5, 0, 0);

        push(1, 0, 2'b00, 2'b00, 1, 1);
        run("enable_zero", 2'b00, 1000, GOOD, GOOD, -1, -1, 0, 0);

        push(1, 0, 2'b00, 2'b11, 1, 1);
        run("both_high", 2'b11, 1000, GOOD, GOOD, 0, 0, 0, 0);
        ch_signature = {BAD, BAD};
        tick(); tick();
        chk("both_high.post_mask", fail_mask, 2'b00);
        chk("both_high.post_pass", pass, 1);

        // ch0 captured at RUN cycle 1, then its signature goes wrong; no limit.
        push(1, 0, 2'b00, 2'b11, 6, 6);
        run("sig_change", 2'b11, 0, GOOD, GOOD, 0, 6, 2, 0);

        // Disabled ch1 powers off with a bad signature and must be ignored.
        push(1, 0, 2'b00, 2'b01, 3, 3);
        run("disabled", 2'b01, 1000, GOOD, BAD, 3, 1, 0, 0);

        push(1, 0, 2'b00, 2'b11, 8, 8);
        run("start_mid_run", 2'b11, 1000, GOOD, GOOD, 3, 8, 0, 5);

        // Abort mid-run with rst during RUN cycle 7.
        ch_enable = 2'b11; timeout_limit = 1000; ch_poweroff = '0;
        ch_signature = {GOOD, GOOD};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("abort.busy_before", busy, 1);
        chk("abort.cycles_before", cycles, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("abort");

        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_zero("rst_over_start");

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/completion_monitor.md
COMPLETION_MONITOR -- requirements
Module: completion_monitor

Interface
REQ-001 Parameter NCH, default 2: number of monitored channels, range 1..8.
REQ-002 Parameter SIG_W, default 32: signature width per channel.
REQ-003 Parameter CNT_W, default 32: cycle counter and timeout width.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle arm request.
REQ-007 Port ch_enable, input, NCH: channel participation mask, sampled at start.
REQ-008 Port timeout_limit, input, CNT_W: cycle budget, sampled at start; 0 = no timeout.
REQ-009 Port exp_sig, input, NCH*SIG_W: expected signatures, channel i in bits [i*SIG_W +: SIG_W], sampled at start.
REQ-010 Port ch_poweroff, input, NCH: per-channel completion level.
REQ-011 Port ch_signature, input, NCH*SIG_W: per-channel result word, same packing as exp_sig.
REQ-012 Port busy, output, 1: high in RUN.
REQ-013 Port done, output, 1: high in DONE.
REQ-014 Port pass, output, 1: done with no failure.
REQ-015 Port fail_timeout, output, 1: the run ended by timeout.
REQ-016 Port fail_mask, output, NCH: channels that captured a mismatching signature or never captured.
REQ-017 Port captured, output, NCH: channels whose signature was captured this run.
REQ-018 Port cycles, output, CNT_W: RUN cycles elapsed; frozen in DONE.

Function
REQ-019 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-020 IDLE or DONE, start=1: the block SHALL latch ch_enable, timeout_limit and exp_sig, and clear captured, fail_mask, fail_timeout and cycles. It SHALL enter RUN on the next edge, so busy=1 the cycle after start.
REQ-021 start in RUN SHALL be ignored.
REQ-022 In RUN, cycles SHALL increment by 1 each cycle, saturating at all-ones.
REQ-023 In RUN, for each enabled, not-yet-captured channel i with ch_poweroff[i]=1:
  - set captured[i];
  - compare ch_signature slice i against the latched exp_sig slice i in that same cycle;
  - on inequality, set fail_mask[i].
REQ-024 Capture SHALL be level-sensitive: a channel already at poweroff=1 on the first RUN cycle is captured that cycle.
REQ-025 After capture, further changes on ch_poweroff[i] or ch_signature slice i SHALL be ignored until the next start.
REQ-026 Disabled channels SHALL never be captured and never flagged.
REQ-027 RUN->DONE when every enabled channel is captured, counting captures made in the current cycle.
REQ-028 RUN->DONE with fail_timeout=1 when timeout_limit!=0, cycles+1==timeout_limit, and REQ-027 does not hold that cycle. Maximum RUN length = timeout_limit cycles.
REQ-029 On a timeout, fail_mask SHALL additionally set every enabled channel that is not captured.
REQ-030 If a capture and the timeout compare occur in the same cycle and complete the set, completion SHALL win: fail_timeout=0.
REQ-031 ch_enable latched as all-zero: RUN SHALL last exactly one cycle, then DONE with pass=1.
REQ-032 pass SHALL equal done AND fail_timeout=0 AND fail_mask=0.
REQ-033 DONE SHALL hold all status outputs stable until start or rst.

Reset
REQ-034 rst=1 SHALL force IDLE and zero every output, cycles and latched configuration. It overrides start.
REQ-035 rst asserted mid-RUN SHALL abort the run without setting done.

Verification
REQ-036 NCH=2, exp_sig={0x3038345A,0x3038345A}, enable=11, limit=1000; ch0 poweroff at RUN cycle 10, ch1 at 20, both signatures correct -> done at cycle 21, pass=1, cycles=20.
REQ-037 Same setup, ch1 signature 0x3038345B -> done, pass=0, fail_mask=10, fail_timeout=0.
REQ-038 limit=50, only ch0 completes -> done after 50 RUN cycles, fail_timeout=1, fail_mask=10, captured=01.
REQ-039 limit=5, ch1 poweroff on RUN cycle 5 with ch0 already captured -> completion wins: pass=1, fail_timeout=0.
REQ-040 enable=00 -> busy for one cycle, pass=1. Separately: start pulsed again mid-RUN -> ignored; rst at RUN cycle 7 -> all outputs 0 next cycle.
REQ-041 Both poweroff already high at start -> captured on RUN cycle 1; signature change after capture does not alter fail_mask.
